y_mux1_unit: RTL and testbench

Single-bit (parameterizable) 2:1 selector used as the basic building block of the datapath mux trees. Output `z` follows `a` when `c` is 0 and `b` when `c` is 1, purely combinationally. A registered copy of the result and a saturating select-toggle counter are provided for pipelined consumers and debug visibility.

---
 rtl/y_mux1_unit_pkg.sv | 6 +
 rtl/y_mux1_unit_if.sv | 25 ++
 rtl/y_mux1_unit.sv | 49 ++++
 tb/tb_y_mux1_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/y_mux1_unit_pkg.sv
// y_mux1_unit shared defaults.
// Parameter defaults for the mux leaf and its debug counter.
package y_mux1_unit_pkg;
   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/y_mux1_unit_if.sv
// y_mux1_unit signal bundle.
// Master drives data/select, slave returns mux results.
interface y_mux1_unit_if
   import y_mux1_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic [WIDTH-1:0] z;
   logic [WIDTH-1:0] z_q;
   logic [CNT_W-1:0] sel_toggles;

   modport master (
      output a, b, c,
      input  z, z_q, sel_toggles
   );

   modport slave (
      input  a, b, c,
      output z, z_q, sel_toggles
   );
endinterface

// File: rtl/y_mux1_unit.sv
// y_mux1_unit: 2:1 mux leaf with registered copy
// and a saturating select-toggle counter.
module y_mux1_unit
   import y_mux1_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   output logic [WIDTH-1:0] z,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] z_q,
   output logic [CNT_W-1:0] sel_toggles
);

   // Pure continuous assign so mux trees need no clock.
   assign z = c ? b : a;

   logic [WIDTH-1:0] zreg_d, zreg_q;
   logic             c_prev_d, c_prev_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      zreg_d   = z;
      c_prev_d = c;
      cnt_d    = cnt_q;
      if ((c != c_prev_q) && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zreg_q   <= '0;
         c_prev_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         zreg_q   <= zreg_d;
         c_prev_q <= c_prev_d;
         cnt_q    <= cnt_d;
      end
   end

   assign z_q         = zreg_q;
   assign sel_toggles = cnt_q;

endmodule

// File: tb/tb_y_mux1_unit.sv
// Bench for y_mux1_unit: vector table, corner
// sequences and randomized run against a model.
module tb_y_mux1_unit;

   logic clk;
   logic rst_n;

   y_mux1_unit_if #(.WIDTH(1), .CNT_W(16)) bus ();
   y_mux1_unit_if #(.WIDTH(1), .CNT_W(2))  sat ();

   assign sat.a = bus.a;
   assign sat.b = bus.b;
   assign sat.c = bus.c;

   y_mux1_unit #(.WIDTH(1), .CNT_W(16)) dut (
      .z(bus.z), .a(bus.a), .b(bus.b), .c(bus.c),
      .clk(clk), .rst_n(rst_n),
      .z_q(bus.z_q), .sel_toggles(bus.sel_toggles)
   );

   y_mux1_unit #(.WIDTH(1), .CNT_W(2)) dut_sat (
      .z(sat.z), .a(sat.a), .b(sat.b), .c(sat.c),
      .clk(clk), .rst_n(rst_n),
      .z_q(sat.z_q), .sel_toggles(sat.sel_toggles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state, updated per rising edge.
   int m_zq   = 0;
   int m_prev = 0;
   int m_cnt  = 0;
   int m_sat  = 0;

   typedef struct {
      logic a;
      logic b;
      logic c;
      logic z;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic drive(input logic ia, input logic ib,
                        input logic ic, input logic ir);
      @(negedge clk);
      bus.a = ia;
      bus.b = ib;
      bus.c = ic;
      rst_n = ir;
   endtask

   task automatic step();
      int cv;
      @(posedge clk);
      cv = int'(bus.c);
      if (!rst_n) begin
         m_zq = 0; m_prev = 0; m_cnt = 0; m_sat = 0;
      end else begin
         m_zq = cv ? int'(bus.b) : int'(bus.a);
         if (cv != m_prev) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 3) m_sat++;
         end
         m_prev = cv;
      end
      #1;
   endtask

   task automatic chk_model();
      chk("rand_zq", 32'(bus.z_q), 32'(m_zq));
      chk("rand_cnt", 32'(bus.sel_toggles), 32'(m_cnt));
      chk("rand_sat", 32'(sat.sel_toggles), 32'(m_sat));
   endtask

   initial begin
      logic ra, rb, rc, rr, ez;
      rst_n = 1'b0;
      bus.a = 1'b0;
      bus.b = 1'b0;
      bus.c = 1'b0;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

      for (int i = 0; i < 8; i++) begin
         bus.a = tbl[i].a;
         bus.b = tbl[i].b;
         bus.c = tbl[i].c;
         #1;
         chk($sformatf("comb%0d", i),
             32'(bus.z), 32'(tbl[i].z));
      end

      // Reset held two edges.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1 chk("rst_z_now", 32'(bus.z), 32'd1);
      step();
      step();
      chk("rst_z", 32'(bus.z), 32'd1);
      chk("rst_zq", 32'(bus.z_q), 32'd0);
      chk("rst_cnt", 32'(bus.sel_toggles), 32'd0);
      chk("rst_sat", 32'(sat.sel_toggles), 32'd0);

      // Pipeline latency and first-edge toggle.
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      #1 chk("pipe_z", 32'(bus.z), 32'd1);
      chk("pipe_zq_pre", 32'(bus.z_q), 32'd0);
      step();
      chk("pipe_zq", 32'(bus.z_q), 32'd1);
      chk("first_tog", 32'(bus.sel_toggles), 32'd1);

      // Toggle sequence 1,0,1,1 after a fresh reset.
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("rst2_cnt", 32'(bus.sel_toggles), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b1); step();
      drive(1'b0, 1'b1, 1'b0, 1'b1); step();
      drive(1'b0, 1'b1, 1'b1, 1'b1); step();
      drive(1'b0, 1'b1, 1'b1, 1'b1); step();
      chk("tog_cnt", 32'(bus.sel_toggles), 32'd3);
      chk("tog_sat3", 32'(sat.sel_toggles), 32'd3);

      // Saturation: 6 more toggles.
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0) ? 1'b0 : 1'b1,
               1'b1);
         step();
         chk($sformatf("sat_hold%0d", i),
             32'(sat.sel_toggles), 32'd3);
      end
      chk("sat_main", 32'(bus.sel_toggles), 32'd9);

      // Reset together with a toggle: reset wins.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk("rst_sat_clr", 32'(sat.sel_toggles), 32'd0);
      chk("rst_tog_cnt", 32'(bus.sel_toggles), 32'd0);
      chk("rst_mid_zq", 32'(bus.z_q), 32'd0);
      chk("rst_mid_z", 32'(bus.z), 32'd1);

      // Unknown select with equal data.
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      bus.c = 1'bx;
      #1 chk("x_sel_eq", 32'(bus.z), 32'd1);
      bus.c = 1'b0;
      step();

      // Randomized run against the model.
      for (int i = 0; i < 300; i++) begin
         ra = 1'($urandom);
         rb = 1'($urandom);
         rc = ($urandom_range(3) == 0) ? bus.c : ~bus.c;
         rr = ($urandom_range(24) == 0) ? 1'b0 : 1'b1;
         drive(ra, rb, rc, rr);
         ez = rc ? rb : ra;
         #1 chk("rand_z", 32'(bus.z), 32'(ez));
         step();
         chk_model();
      end

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
